// File: rtl/div_seq_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_seq_pkg;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam int unsigned DivMaxWidth = 64;

  // Two's-complement negate at the widest legal operand size; callers truncate to WIDTH.
  function automatic logic [DivMaxWidth-1:0] twos_negate(input logic [DivMaxWidth-1:0] x);
    return ~x + DivMaxWidth'(1);
  endfunction

endpackage

// File: rtl/div_seq.sv
// Sequential restoring divider: one quotient bit per clock, signed or unsigned,
// with divide-by-zero short path, abort, and a hold-until-acknowledged result.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               div_by_zero_o,
  output logic               busy_o
);

  localparam int unsigned DivW = 2 * WIDTH + 1;
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  div_state_e         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [DivW-1:0]    dividend_q, dividend_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic               sign1_q, sign1_d;
  logic               sign2_q, sign2_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;
  logic               dbz_q, dbz_d;
  logic               busy_q, busy_d;

  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH-1:0]   diff;
  logic               rem_ge;
  logic [WIDTH-1:0]   quo_raw, rem_raw, quo_fix, rem_fix;

  // Operand magnitudes and one restoring step on the partial remainder.
  always_comb begin
    mag1 = (signed_div_i && opdata1_i[WIDTH-1])
         ? WIDTH'(twos_negate(DivMaxWidth'(opdata1_i))) : opdata1_i;
    mag2 = (signed_div_i && opdata2_i[WIDTH-1])
         ? WIDTH'(twos_negate(DivMaxWidth'(opdata2_i))) : opdata2_i;
    // Upper remainder bit can be set once the divisor exceeds half range.
    rem_ge  = dividend_q[2*WIDTH:WIDTH] >= {1'b0, divisor_q};
    diff    = dividend_q[2*WIDTH-1:WIDTH] - divisor_q;
    quo_raw = dividend_q[WIDTH-1:0];
    rem_raw = dividend_q[2*WIDTH:WIDTH+1];
    quo_fix = (sign1_q ^ sign2_q) ? WIDTH'(twos_negate(DivMaxWidth'(quo_raw))) : quo_raw;
    rem_fix = sign1_q ? WIDTH'(twos_negate(DivMaxWidth'(rem_raw))) : rem_raw;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    sign1_d    = sign1_q;
    sign2_d    = sign2_q;
    result_d   = result_q;
    ready_d    = ready_q;
    dbz_d      = dbz_q;

    unique case (state_q)
      DIV_FREE: begin
        if (annul_i) begin
          state_d = DIV_FREE;
        end else if (start_i == DivStart) begin
          if (opdata2_i == '0) begin
            state_d = DIV_BYZERO;
          end else begin
            state_d    = DIV_ON;
            cnt_d      = '0;
            dividend_d = {{WIDTH{1'b0}}, mag1, 1'b0};
            divisor_d  = mag2;
            sign1_d    = signed_div_i & opdata1_i[WIDTH-1];
            sign2_d    = signed_div_i & opdata2_i[WIDTH-1];
          end
        end
      end
      DIV_BYZERO: begin
        if (annul_i) begin
          state_d = DIV_FREE;
        end else begin
          state_d  = DIV_END;
          result_d = '0;
          ready_d  = DivResultReady;
          dbz_d    = 1'b1;
        end
      end
      DIV_ON: begin
        if (annul_i) begin
          state_d = DIV_FREE;
        end else if (cnt_q == CntW'(WIDTH)) begin
          state_d  = DIV_END;
          result_d = {rem_fix, quo_fix};
          ready_d  = DivResultReady;
          dbz_d    = 1'b0;
        end else begin
          cnt_d      = cnt_q + CntW'(1);
          dividend_d = rem_ge ? {diff, dividend_q[WIDTH-1:0], 1'b1}
                              : {dividend_q[2*WIDTH-1:0], 1'b0};
        end
      end
      DIV_END: begin
        if (start_i == DivStop) begin
          state_d  = DIV_FREE;
          result_d = '0;
          ready_d  = DivResultNotReady;
          dbz_d    = 1'b0;
        end
      end
    endcase

    busy_d = (state_d != DIV_FREE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= DIV_FREE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      sign1_q    <= 1'b0;
      sign2_q    <= 1'b0;
      result_q   <= '0;
      ready_q    <= DivResultNotReady;
      dbz_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      sign1_q    <= sign1_d;
      sign2_q    <= sign2_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
      dbz_q      <= dbz_d;
      busy_q     <= busy_d;
    end
  end

  assign result_o      = result_q;
  assign ready_o       = ready_q;
  assign div_by_zero_o = dbz_q;
  assign busy_o        = busy_q;

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; legal range 4..64.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 start_i  in  1  request; held high by requester until ready_o seen, then dropped.
REQ-005 annul_i  in  1  abort current operation (pipeline flush).
REQ-006 signed_div_i  in  1  1 = two's-complement divide, 0 = unsigned.
REQ-007 opdata1_i  in  WIDTH  dividend.
REQ-008 opdata2_i  in  WIDTH  divisor.
REQ-009 result_o  out  2*WIDTH  {remainder, quotient}; remainder in upper WIDTH bits.
REQ-010 ready_o  out  1  result valid.
REQ-011 div_by_zero_o  out  1  set with ready_o when divisor was zero.
REQ-012 busy_o  out  1  high in every state except FREE.

Function
REQ-013 States FREE, BYZERO, ON, END; encoding 2 bits.
REQ-014 FREE: annul_i high -> stay FREE; else start_i high and opdata2_i==0 -> BYZERO; else start_i high -> ON, operands and signed_div_i latched, cnt=0.
REQ-015 Signed mode latches magnitudes (two's-complement negate of negative operands) plus both sign bits; unsigned latches raw values.
REQ-016 ON: one restoring quotient bit per edge, cnt increments; edge with cnt==WIDTH -> END, no iteration performed on that edge.
REQ-017 Entering END registers result_o, ready_o=1; latency = WIDTH+1 edges after the edge sampling start_i.
REQ-018 Signed result: quotient negated when latched signs differ; remainder carries dividend sign.
REQ-019 Signed min/-1 (e.g. 0x80000000 / 0xFFFFFFFF): quotient = min value, remainder 0, no flag.
REQ-020 BYZERO: next edge -> END with result_o=0, div_by_zero_o=1; latency 2 edges.
REQ-021 END: ready_o, result_o, div_by_zero_o held stable while start_i high; start_i low -> FREE, ready_o=0, div_by_zero_o=0, result_o=0 on that edge.
REQ-022 annul_i high in ON or BYZERO -> FREE on next edge, ready_o stays 0, partial result discarded.
REQ-023 annul_i in END ignored; handshake per REQ-021 governs exit.
REQ-024 Operand/mode inputs ignored outside the FREE-accept edge.
REQ-025 start_i and annul_i high together in FREE -> annul wins.
REQ-026 Back-to-back: new start accepted only in FREE, minimum one FREE cycle between operations.

Reset
REQ-027 rst low at edge -> state FREE, cnt 0, result_o 0, ready_o 0, div_by_zero_o 0, busy_o 0, datapath registers 0.
REQ-028 Reset mid-operation (any state) aborts with no ready_o pulse; first edge after release behaves as FREE.

Structure
REQ-029 Shared package holds state encoding, DivStart/DivStop, DivResultReady/DivResultNotReady constants and a WIDTH-generic two's-complement negate function.
REQ-030 Single module, no sub-module; iteration datapath is one (2*WIDTH+1)-bit shift/subtract register.

Verification
REQ-031 WIDTH=32 unsigned 100/7, start held -> after 33 edges ready_o=1, result_o={2,14}.
REQ-032 WIDTH=32 signed -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-033 5/0 -> after 2 edges ready_o=1, div_by_zero_o=1, result_o=0; drop start -> all low next edge.
REQ-034 annul_i pulse at cnt=10 -> FREE next edge, ready_o never rises; following 9/3 returns {0,3}.
REQ-035 start held 5 extra cycles in END -> result_o stable, ready_o high throughout; rst low mid-ON -> FREE, outputs 0.
REQ-036 WIDTH=8 unsigned 200/3 -> after 9 edges result_o={2,66}.
